// File: rtl/core_bus_pkg.sv
// Shared definitions for the core load/store bus: default widths, responder
// wait-state default and the responder FSM state encoding.
package core_bus_pkg;

  localparam int CORE_ADDR_W           = 8;
  localparam int CORE_DATA_W           = 16;
  localparam int CORE_MEM_WAIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/core_mem_array.sv
// Single-port RAM, DEPTH x DATA_W: synchronous write gated by clk_en,
// asynchronous read of the addressed word. Contents are never reset.
module core_mem_array #(
  parameter  int DEPTH  = 256,
  parameter  int DATA_W = 16,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              clk_en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clk_en && we) begin
      mem[idx] <= wdata;
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the core load/store bus with fixed wait states.
// Optional macro CORE_MEM_BOUNDS_ERR_EN adds an err output for addr >= DEPTH.
module core_mem_responder
  import core_bus_pkg::*;
#(
  parameter int ADDR_W      = CORE_ADDR_W,
  parameter int DATA_W      = CORE_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = CORE_MEM_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
`ifdef CORE_MEM_BOUNDS_ERR_EN
  output logic              err,
`endif
  output mem_state_e        dbg_state
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Handshake: the core raises req with we/addr/wdata and holds them until it
  // sees the one-cycle ack; in the ack cycle it either drops req or presents
  // the next request, which is accepted on that same enabled edge.
  mem_state_e        state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              accept;
  logic              wait_done;
  logic              fire;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rd;

  assign accept    = req && (state == IDLE || state == RESP);
  assign wait_done = (state == WAIT) && (cnt <= 4'd1);
  assign fire      = (accept && (WAIT_CYCLES == 0)) || wait_done;

  // With zero wait states the access happens on the accept edge itself, so the
  // live bus values are used instead of the not-yet-latched copies.
  assign acc_we    = accept ? we    : lat_we;
  assign acc_addr  = accept ? addr  : lat_addr;
  assign acc_wdata = accept ? wdata : lat_wdata;
  assign in_range  = {1'b0, acc_addr} < DEPTH_L;
  assign mem_idx   = in_range ? acc_addr[IDX_W-1:0] : '0;

  core_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .clk_en  (clk_en),
    .we      (fire && acc_we && in_range),
    .idx     (mem_idx),
    .wdata   (acc_wdata),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef CORE_MEM_BOUNDS_ERR_EN
      err       <= 1'b0;
`endif
    end else if (clk_en) begin
      if (accept) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
`ifdef CORE_MEM_BOUNDS_ERR_EN
      err <= fire && !in_range;
      if (fire && !acc_we) rdata <= in_range ? mem_rd : '1;
`else
      if (fire && !acc_we) rdata <= in_range ? mem_rd : '0;
`endif
      case (state)
        IDLE, RESP: begin
          if (req) begin
            cnt <= WAIT_LD;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              ack   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
              ack   <= 1'b0;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            ack   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (wait_done) begin
            state <= RESP;
            ack   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: three instances (default, zero wait
// states, DEPTH=200) share one request bus and are exercised one at a time.
module tb_core_mem_responder;
  import core_bus_pkg::*;

`ifdef CORE_MEM_BOUNDS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;

  logic [2:0]  ack_v;
  logic [2:0]  busy_v;
  logic [2:0]  err_v;
  logic [15:0] rdata_v [3];
  mem_state_e  st_v    [3];

  int n_cmp = 0;
  int n_bad = 0;

  core_mem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) u_dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]),
`ifdef CORE_MEM_BOUNDS_ERR_EN
    .err(err_v[0]),
`endif
    .dbg_state(st_v[0])
  );

  core_mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]),
`ifdef CORE_MEM_BOUNDS_ERR_EN
    .err(err_v[1]),
`endif
    .dbg_state(st_v[1])
  );

  core_mem_responder #(.WAIT_CYCLES(2), .DEPTH(200)) u_dut_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack_v[2]), .rdata(rdata_v[2]), .busy(busy_v[2]),
`ifdef CORE_MEM_BOUNDS_ERR_EN
    .err(err_v[2]),
`endif
    .dbg_state(st_v[2])
  );

`ifndef CORE_MEM_BOUNDS_ERR_EN
  assign err_v = '0;
`endif

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req = 1'b0;
    we  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Driver: one transaction, returns enabled edges from request to ack (-1 on timeout)
  task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [15:0] dd,
                     output int lat, output logic [15:0] rd, output logic e);
    bit got;
    got   = 1'b0;
    lat   = 0;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = dd;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      if (ack_v[d]) got = 1'b1;
    end
    rd  = rdata_v[d];
    e   = err_v[d];
    req = 1'b0;
    we  = 1'b0;
    if (!got) lat = -1;
  endtask

  typedef struct {
    int          dut;
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tab [14];

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        e;
    int          prev_dut;
    logic [15:0] oor_rd;

    oor_rd = ERR_EN ? 16'hFFFF : 16'h0000;

    // dut, we, addr, wdata, expected rdata after ack, expected err, latency
    tab[0]  = '{0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 1'b0, 3};
    tab[1]  = '{0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0, 3};
    tab[2]  = '{0, 1'b1, 8'h11, 16'h5A5A, 16'hBEEF, 1'b0, 3};
    tab[3]  = '{0, 1'b1, 8'h10, 16'h0001, 16'hBEEF, 1'b0, 3};
    tab[4]  = '{0, 1'b0, 8'h11, 16'h0000, 16'h5A5A, 1'b0, 3};
    tab[5]  = '{0, 1'b0, 8'h10, 16'h0000, 16'h0001, 1'b0, 3};
    tab[6]  = '{1, 1'b1, 8'h00, 16'hA000, 16'h0000, 1'b0, 1};
    tab[7]  = '{1, 1'b1, 8'h01, 16'hA001, 16'h0000, 1'b0, 1};
    tab[8]  = '{1, 1'b1, 8'h02, 16'hA002, 16'h0000, 1'b0, 1};
    tab[9]  = '{1, 1'b1, 8'h03, 16'hA003, 16'h0000, 1'b0, 1};
    tab[10] = '{2, 1'b1, 8'hC7, 16'h7777, 16'h0000, 1'b0, 3};
    tab[11] = '{2, 1'b0, 8'hC7, 16'h0000, 16'h7777, 1'b0, 3};
    tab[12] = '{2, 1'b1, 8'hF0, 16'h1234, 16'h7777, ERR_EN, 3};
    tab[13] = '{2, 1'b0, 8'hF0, 16'h0000, oor_rd, ERR_EN, 3};

    rst    = 1'b0;
    clk_en = 1'b1;
    req    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ack[%0d]", d), 32'(ack_v[d]), 32'd0);
      check($sformatf("reset_busy[%0d]", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset_rdata[%0d]", d), 32'(rdata_v[d]), 32'd0);
      check($sformatf("reset_state[%0d]", d), 32'(st_v[d]), 32'(IDLE));
    end
    rst = 1'b1;

    // Table-driven transactions; reset whenever the checked instance changes
    prev_dut = 0;
    for (int i = 0; i < 14; i++) begin
      if (tab[i].dut != prev_dut) pulse_reset();
      prev_dut = tab[i].dut;
      txn(tab[i].dut, tab[i].w, tab[i].a, tab[i].d, lat, rd, e);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tab[i].exp_lat));
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tab[i].exp_rd));
`ifdef CORE_MEM_BOUNDS_ERR_EN
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tab[i].exp_err));
`endif
    end

    // Zero wait states: back-to-back reads with req held high
    pulse_reset();
    req = 1'b1;
    we  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      step();
      check($sformatf("b2b_ack%0d", i), 32'(ack_v[1]), 32'd1);
      check($sformatf("b2b_rdata%0d", i), 32'(rdata_v[1]), 32'(16'hA000 + 16'(i)));
    end
    req = 1'b0;
    step();
    check("b2b_idle_ack", 32'(ack_v[1]), 32'd0);

    // clk_en toggling during WAIT freezes the counter; ack held while disabled
    pulse_reset();
    req  = 1'b1;
    we   = 1'b0;
    addr = 8'h10;
    step();
    check("cen_busy_e1", 32'(busy_v[0]), 32'd1);
    check("cen_state_e1", 32'(st_v[0]), 32'(WAIT));
    clk_en = 1'b0;
    step();
    check("cen_busy_off1", 32'(busy_v[0]), 32'd1);
    step();
    check("cen_ack_off2", 32'(ack_v[0]), 32'd0);
    clk_en = 1'b1;
    step();
    check("cen_ack_e2", 32'(ack_v[0]), 32'd0);
    check("cen_busy_e2", 32'(busy_v[0]), 32'd1);
    step();
    check("cen_ack_e3", 32'(ack_v[0]), 32'd1);
    check("cen_rdata_e3", 32'(rdata_v[0]), 32'h0001);
    req    = 1'b0;
    clk_en = 1'b0;
    step();
    check("cen_ack_hold1", 32'(ack_v[0]), 32'd1);
    step();
    check("cen_ack_hold2", 32'(ack_v[0]), 32'd1);
    clk_en = 1'b1;
    step();
    check("cen_ack_drop", 32'(ack_v[0]), 32'd0);
    check("cen_busy_drop", 32'(busy_v[0]), 32'd0);

    // Reset in the middle of WAIT aborts a pending write
    pulse_reset();
    txn(0, 1'b1, 8'h20, 16'h0BAD, lat, rd, e);
    check("rstw_pre_latency", 32'(lat), 32'd3);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 8'h20;
    wdata = 16'hDEAD;
    step();
    check("rstw_busy", 32'(busy_v[0]), 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("rstw_async_busy", 32'(busy_v[0]), 32'd0);
    check("rstw_async_ack", 32'(ack_v[0]), 32'd0);
    check("rstw_async_state", 32'(st_v[0]), 32'(IDLE));
    req = 1'b0;
    we  = 1'b0;
    #1;
    rst = 1'b1;
    step();
    txn(0, 1'b0, 8'h20, 16'h0000, lat, rd, e);
    check("rstw_read_latency", 32'(lat), 32'd3);
    check("rstw_read_rdata", 32'(rd), 32'h0BAD);

    // A request change during WAIT is ignored
    pulse_reset();
    txn(0, 1'b1, 8'h30, 16'h3333, lat, rd, e);
    txn(0, 1'b1, 8'h31, 16'h4444, lat, rd, e);
    step();
    req  = 1'b1;
    we   = 1'b0;
    addr = 8'h30;
    step();
    addr = 8'h31;
    step();
    check("ign_busy", 32'(busy_v[0]), 32'd1);
    check("ign_ack_early", 32'(ack_v[0]), 32'd0);
    step();
    check("ign_ack", 32'(ack_v[0]), 32'd1);
    check("ign_rdata", 32'(rdata_v[0]), 32'h3333);
    req = 1'b0;
    step();
    check("ign_ack_after", 32'(ack_v[0]), 32'd0);
    check("ign_busy_after", 32'(busy_v[0]), 32'd0);
    step();
    check("ign_no_second_ack", 32'(ack_v[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
